// File: rtl/enc_pkg.sv
// ============================================================================
//  Module   : enc_pkg
//  Brief    : Shared types and sizing constants for the sequential 16-to-4 encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int ENC_WIDTH = 16;
  localparam int ENC_IDX_W = 4;
  localparam int ENC_CNT_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/encoder16_seq_lsb_index.sv
// ============================================================================
//  Module   : lsb_index
//  Brief    : Combinational lowest-set-bit encoder with a found flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_index #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/encoder16_seq.sv
// ============================================================================
//  Module   : encoder16_seq
//  Brief    : Sequential 16-to-4 encoder; emits the index of every set bit of an
//             accepted request vector, lowest first, one per output handshake.
//             Optional macro ENC_COUNT_EN enables the popcount output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder16_seq
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_WIDTH-1:0] d,
  output logic [ENC_IDX_W-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 y_last,
  output logic                 zero,
  output logic [ENC_CNT_W-1:0] count
);

  localparam int WIDTH = ENC_WIDTH;
  localparam int IDX_W = ENC_IDX_W;

  enc_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_pend, w_pend_next;
  logic             r_zero, w_zero_next;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_last;

  lsb_index #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb_index (
    .vec   (r_pend),
    .idx   (w_idx),
    .found (w_found)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign w_last = w_found && ((r_pend & (r_pend - WIDTH'(1))) == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_zero  <= w_zero_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_zero_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (d == '0) begin
            w_zero_next = 1'b1;
          end else begin
            w_pend_next  = d;
            w_state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (y_ready) begin
          w_pend_next = r_pend & ~(WIDTH'(1) << w_idx);
          if (w_last) begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pend_next  = '0;
      end
    endcase
  end

  assign in_ready = (r_state == IDLE);
  assign y_valid  = (r_state == SCAN);
  assign y        = w_idx;
  assign y_last   = w_last;
  assign zero     = r_zero;

`ifdef ENC_COUNT_EN
  logic [ENC_CNT_W-1:0] r_count;
  logic [ENC_CNT_W-1:0] w_popcnt;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + ENC_CNT_W'(d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (in_valid && in_ready) begin
      r_count <= w_popcnt;
    end
  end

  assign count = r_count;
`else
  assign count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_encoder16_seq.sv
// ============================================================================
//  Module   : tb_encoder16_seq
//  Brief    : Self-checking bench for encoder16_seq against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder16_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d;
  logic [3:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic        y_last;
  logic        zero;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: remaining indices of the current vector, zero pulse, popcount.
  int          exp_q[$];
  bit          m_zero  = 1'b0;
  int          m_count = 0;
  logic [4:0]  log_q[$];

  always #5 clk = ~clk;

  encoder16_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_last   (y_last),
    .zero     (zero),
    .count    (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_zero  = 1'b0;
      m_count = 0;
    end else begin
      m_zero = 1'b0;
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) if (d[i]) exp_q.push_back(i);
          m_zero  = (d == 16'h0);
          m_count = $countones(d);
        end
      end else if (y_ready) begin
        log_q.push_back({y_last, y});
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", in_ready, exp_q.size() == 0);
      check("y_valid", y_valid, exp_q.size() != 0);
      check("zero", zero, m_zero);
`ifdef ENC_COUNT_EN
      check("count", count, m_count);
`else
      check("count", count, 0);
`endif
      if (exp_q.size() != 0) begin
        check("y", y, exp_q[0]);
        check("y_last", y_last, exp_q.size() == 1);
      end
    end
  end

  task automatic send(input logic [15:0] vec);
    @(negedge clk);
    in_valid = 1'b1;
    d        = vec;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    check({name, "_idle_timeout"}, ok, 1);
  endtask

  // Compare logged handshakes with n indices packed as nibbles, lowest first.
  task automatic check_log(input string name, input int n, input logic [63:0] nib, input bit last_on_final);
    check({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check({name, "_entry"}, log_q[i], {(last_on_final && i == n - 1), nib[i*4 +: 4]});
    end
    log_q.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    d        = 16'h0;
    y_ready  = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_y_valid", y_valid, 0);
    check("rst_zero", zero, 0);
    check("rst_count", count, 0);

    // Single lowest bit
    y_ready = 1'b1;
    log_q.delete();
    send(16'h0001);
    check("t1_y", y, 0);
    check("t1_last", y_last, 1);
    check("t1_valid", y_valid, 1);
    @(negedge clk);
    check("t1_in_ready", in_ready, 1);
    check("t1_y_valid_off", y_valid, 0);
    check_log("t1", 1, 64'h0, 1'b1);

    // Spread bits, full-rate consumer
    send(16'h8421);
    wait_idle("t2");
    check_log("t2", 4, 64'hFA50, 1'b1);

    // All-zero vector
    send(16'h0000);
    check("t3_zero", zero, 1);
    check("t3_y_valid", y_valid, 0);
    check("t3_in_ready", in_ready, 1);
    @(negedge clk);
    check("t3_zero_pulse", zero, 0);

    // Back-pressure holds the output stable
    y_ready = 1'b0;
    send(16'h00C0);
    for (int k = 0; k < 3; k++) begin
      check("t4_y_hold", y, 6);
      check("t4_last_hold", y_last, 0);
      check("t4_valid_hold", y_valid, 1);
      @(negedge clk);
    end
    y_ready = 1'b1;
    wait_idle("t4");
    check_log("t4", 2, 64'h76, 1'b1);

    // Reset in the middle of a scan
    send(16'hFFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_y_valid", y_valid, 0);
    check("t5_in_ready", in_ready, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_still_idle", y_valid, 0);
    check_log("t5", 3, 64'h210, 1'b0);

    // Popcount, and in_valid during SCAN must be ignored
    send(16'hF0F1);
`ifdef ENC_COUNT_EN
    check("t6_count", count, 9);
`else
    check("t6_count", count, 0);
`endif
    in_valid = 1'b1;
    d        = 16'h0003;
    repeat (5) begin
      @(negedge clk);
      check("t6_in_ready_scan", in_ready, 0);
    end
    in_valid = 1'b0;
    wait_idle("t6");
    check_log("t6", 9, 64'hFEDC76540, 1'b1);
`ifdef ENC_COUNT_EN
    check("t6_count_held", count, 9);
`endif

    // Highest bit alone, then a full vector
    send(16'h8000);
    check("t7_y", y, 15);
    check("t7_last", y_last, 1);
    wait_idle("t7");
    check_log("t7", 1, 64'hF, 1'b1);
    send(16'hFFFF);
    wait_idle("t8");
    check_log("t8", 16, 64'hFEDCBA9876543210, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
